// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity selectors shared by the UART blocks
package uart_pkg;
    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PAR, STOP} uart_tx_state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_tx_rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of a level already in this clock domain
module rise_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic prev_q;
    // remember last cycle's level so a 0->1 step can be seen
    always_ff @(posedge clk_in) prev_q <= rst ? 1'b0 : in;
    assign pulse = in & ~prev_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter paced by a divided baud square wave
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD)) begin : g_bad_param
        $error("uart_tx: unsupported parameter combination");
    end
    uart_tx_state_t       state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [2:0]           cnt_q;
    logic                 stop_q;
    logic                 tx_q;
    logic                 tick;
    logic                 last_stop;
    logic                 accept;
    logic                 par_d;
    rise_detect u_rise (
        .clk_in(clk_in),
        .rst   (rst),
        .in    (baud_clk),
        .pulse (tick)
    );
    assign last_stop = stop_q == 1'(STOP_BITS - 1);
    assign tx_ready  = state_q == IDLE || (state_q == STOP && last_stop && tick);
    assign accept    = tx_valid && tx_ready;
    assign par_d     = ^tx_data ^ (PARITY == PARITY_ODD);
    assign tx        = tx_q;
    assign busy      = state_q != IDLE;
    // frame sequencer: every bit change lands on a baud tick so each bit lasts one full period
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            if (accept) begin
                shift_q <= tx_data;
                par_q   <= par_d;
            end
            case (state_q)
                IDLE:  if (accept) state_q <= ALIGN;
                ALIGN: if (tick) begin
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (tick) begin
                    tx_q    <= shift_q[0];
                    cnt_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (tick) begin
                    if (cnt_q == 3'(DATA_BITS - 1)) begin
                        tx_q    <= PARITY != PARITY_NONE ? par_q : 1'b1;
                        state_q <= PARITY != PARITY_NONE ? PAR : STOP;
                        stop_q  <= 1'b0;
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                PAR: if (tick) begin
                    tx_q    <= 1'b1;
                    stop_q  <= 1'b0;
                    state_q <= STOP;
                end
                STOP: if (tick) begin
                    stop_q <= last_stop ? 1'b0 : stop_q + 1'b1;
                    if (last_stop) begin
                        tx_q    <= ~accept;
                        state_q <= accept ? START : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frames on four configurations checked against a frame-level line model
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int PER   [4] = '{6, 4, 4, 10};
    localparam int PMODE [4] = '{0, 1, 2, 0};
    localparam int STOPS [4] = '{1, 1, 1, 2};
    logic       clk = 1'b0;
    logic       rst   [4];
    logic       baud  [4];
    logic [7:0] data  [4];
    logic       valid [4];
    logic       rdy   [4];
    logic       txl   [4];
    logic       bsy   [4];
    int         bc    [4];
    int         ofs   [4];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pend [$];

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 4; i++) begin
            bc[i]   <= (bc[i] + 1) % PER[i];
            baud[i] <= ((bc[i] + ofs[i]) % PER[i]) >= PER[i] / 2;
        end

    uart_tx u0 (.clk_in(clk), .rst(rst[0]), .baud_clk(baud[0]), .tx_data(data[0]), .tx_valid(valid[0]),
                .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx #(.PARITY(1)) u1 (.clk_in(clk), .rst(rst[1]), .baud_clk(baud[1]), .tx_data(data[1]), .tx_valid(valid[1]),
                .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx #(.PARITY(2)) u2 (.clk_in(clk), .rst(rst[2]), .baud_clk(baud[2]), .tx_data(data[2]), .tx_valid(valid[2]),
                .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx #(.STOP_BITS(2)) u3 (.clk_in(clk), .rst(rst[3]), .baud_clk(baud[3]), .tx_data(data[3]), .tx_valid(valid[3]),
                .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // send the bytes in pend on instance i, record the line, then compare with the expected frames
    task automatic run(input int i, input int wait0, input bit disturb);
        int   p      = PER[i];
        int   nf     = 9 + (PMODE[i] != 0) + STOPS[i];
        int   cnt    = pend.size();
        int   budget = wait0 + cnt * (nf + 2) * p + 2 * p + 20;
        int   k      = 0;
        int   e      = -1;
        bit   upd    = 0;
        bit   pulse  = 0;
        logic b_prev;
        logic s_tx [$], s_rdy [$], s_bsy [$], s_tick [$];
        logic x_tx [$], x_rdy [$], x_bsy [$];
        int   acc [$];
        @(negedge clk);
        b_prev = baud[i];
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (pulse) begin
                valid[i] = 1'b0;
                pulse = 0;
            end
            if (upd) begin
                upd = 0;
                k++;
                if (k < cnt) data[i] = pend[k];
                else valid[i] = 1'b0;
            end
            if (n == wait0 && cnt > 0) begin
                valid[i] = 1'b1;
                data[i] = pend[0];
            end
            s_tx.push_back(txl[i]);
            s_rdy.push_back(rdy[i]);
            s_bsy.push_back(bsy[i]);
            s_tick.push_back(baud[i] & ~b_prev);
            b_prev = baud[i];
            if (valid[i] && rdy[i]) begin
                acc.push_back(n);
                upd = 1;
            end else if (disturb && !valid[i]) begin
                data[i] = 8'($urandom);
                if (k >= cnt && acc.size() > 0 && !rdy[i] && $urandom_range(0, 7) == 0) begin
                    valid[i] = 1'b1;
                    pulse = 1;
                end
            end
        end
        check($sformatf("u%0d accepts", i), acc.size(), cnt);
        for (int n = 0; n < budget; n++) begin
            x_tx.push_back(1'b1);
            x_rdy.push_back(1'b1);
            x_bsy.push_back(1'b0);
        end
        for (int f = 0; f < acc.size(); f++) begin
            int   a = acc[f];
            int   s;
            int   t;
            logic fb [$];
            fb.push_back(1'b0);
            for (int j = 0; j < 8; j++) fb.push_back(pend[f][j]);
            if (PMODE[i] != 0) fb.push_back(1'(($countones(pend[f]) % 2) ^ (PMODE[i] == 2 ? 1 : 0)));
            for (int j = 0; j < STOPS[i]; j++) fb.push_back(1'b1);
            if (e >= 0 && a == e - 1) s = e;
            else begin
                t = a + 1;
                while (t < budget && !s_tick[t]) t++;
                s = t + 1;
            end
            for (int j = 0; j < nf * p; j++) if (s + j < budget) x_tx[s + j] = fb[j / p];
            e = s + nf * p;
            for (int m = a + 1; m < e && m < budget; m++) x_bsy[m] = 1'b1;
            for (int m = a + 1; m < e - 1 && m < budget; m++) x_rdy[m] = 1'b0;
        end
        for (int n = 0; n < budget; n++) begin
            check($sformatf("u%0d tx@%0d", i, n), s_tx[n], x_tx[n]);
            check($sformatf("u%0d ready@%0d", i, n), s_rdy[n], x_rdy[n]);
            check($sformatf("u%0d busy@%0d", i, n), s_bsy[n], x_bsy[n]);
        end
    endtask

    // start a frame, pulse reset in the middle of the data bits, expect an immediate clean idle line
    task automatic reset_mid(input int i);
        int p = PER[i];
        int w = 0;
        @(negedge clk);
        valid[i] = 1'b1;
        data[i] = 8'($urandom);
        @(negedge clk);
        valid[i] = 1'b0;
        while (txl[i] && w < 3 * p) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("u%0d start fall", i), txl[i], 0);
        repeat (3 * p) @(negedge clk);
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        check($sformatf("u%0d rst tx", i), txl[i], 1);
        check($sformatf("u%0d rst busy", i), bsy[i], 0);
        check($sformatf("u%0d rst ready", i), rdy[i], 1);
        for (int n = 0; n < 2 * p; n++) begin
            @(negedge clk);
            check($sformatf("u%0d post-rst tx@%0d", i, n), txl[i], 1);
            check($sformatf("u%0d post-rst busy@%0d", i, n), bsy[i], 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            valid[i] = 1'b0;
            data[i] = '0;
            ofs[i] = $urandom_range(0, PER[i] - 1);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u%0d idle tx", i), txl[i], 1);
                check($sformatf("u%0d idle ready", i), rdy[i], 1);
                check($sformatf("u%0d idle busy", i), bsy[i], 0);
            end
        end
        pend = '{8'hA5};
        run(0, 3, 0);
        run(1, 2, 0);
        run(2, 5, 0);
        pend = '{8'h55, 8'h0F};
        run(3, 1, 0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) begin
                pend.delete();
                repeat ($urandom_range(1, 3)) pend.push_back(8'($urandom));
                run(i, $urandom_range(0, 2 * PER[i]), 1);
            end
        reset_mid(0);
        pend = '{8'h3C};
        run(0, 2, 0);
        reset_mid(3);
        pend = '{8'h3C};
        run(3, 4, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
